// File: rtl/wb_sched.sv
// Register-file write-port scheduler: load returns preempt core writebacks, which queue in order.
// Define WB_SCHED_PERF_EN to add saturating stall/defer/squash counters.
module wb_sched #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_wb_valid,
  output logic            core_wb_ready,
  input  logic [4:0]      core_wb_rd,
  input  logic [1:0]      core_wb_sel,
  input  logic [XLEN-1:0] pcplus4,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] immu,
  input  logic            ld_issue_valid,
  input  logic [4:0]      ld_issue_rd,
  input  logic            mem_rsp_valid,
  input  logic [4:0]      mem_rsp_rd,
  input  logic [XLEN-1:0] readmemdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [1:0]      wb_src,
  output logic [31:0]     ld_pending
`ifdef WB_SCHED_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     defer_cnt,
  output logic [15:0]     squash_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [1:0] SRC_LOAD = 2'b11;

  logic [4:0]      q_rd_mem   [DEPTH];
  logic [1:0]      q_sel_mem  [DEPTH];
  logic [XLEN-1:0] q_data_mem [DEPTH];

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pend_q, pend_d;
  logic [31:0]     squash_q, squash_d;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]      wb_src_q, wb_src_d;

  logic            accept;
  logic            core_wr;
  logic [XLEN-1:0] core_data;
  logic            q_empty;
  logic            pop;
  logic            bypass;
  logic            push;

  assign core_wb_ready = (count_q != CW'(DEPTH));
  assign accept        = core_wb_valid && core_wb_ready;
  // Illegal selects and x0 targets are accepted but never reach the port.
  assign core_wr       = accept && (core_wb_sel != 2'b11) && (core_wb_rd != 5'd0);
  assign q_empty       = (count_q == '0);
  assign pop           = !mem_rsp_valid && !q_empty;
  assign bypass        = !mem_rsp_valid && q_empty && core_wr;
  assign push          = core_wr && !bypass;

  always_comb begin
    core_data = result;
    case (core_wb_sel)
      2'b00:   core_data = pcplus4;
      2'b01:   core_data = result;
      2'b10:   core_data = immu;
      default: core_data = result;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_src_d   = wb_src_q;
    if (mem_rsp_valid) begin
      rf_we_d    = (mem_rsp_rd != 5'd0) && !squash_q[mem_rsp_rd];
      rf_waddr_d = mem_rsp_rd;
      rf_wdata_d = readmemdata;
      wb_src_d   = SRC_LOAD;
    end else if (!q_empty) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = q_rd_mem[head_q];
      rf_wdata_d = q_data_mem[head_q];
      wb_src_d   = q_sel_mem[head_q];
    end else if (core_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = core_wb_rd;
      rf_wdata_d = core_data;
      wb_src_d   = core_wb_sel;
    end
  end

  // Later assignments take priority: issue over response over core squash.
  always_comb begin
    pend_d   = pend_q;
    squash_d = squash_q;
    if (core_wr && pend_q[core_wb_rd]) begin
      squash_d[core_wb_rd] = 1'b1;
    end
    if (mem_rsp_valid) begin
      pend_d[mem_rsp_rd]   = 1'b0;
      squash_d[mem_rsp_rd] = 1'b0;
    end
    if (ld_issue_valid && (ld_issue_rd != 5'd0)) begin
      pend_d[ld_issue_rd]   = 1'b1;
      squash_d[ld_issue_rd] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd_mem[tail_q]   <= core_wb_rd;
      q_sel_mem[tail_q]  <= core_wb_sel;
      q_data_mem[tail_q] <= core_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      squash_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_src_q   <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      squash_q   <= squash_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign wb_src     = wb_src_q;
  assign ld_pending = pend_q;

`ifdef WB_SCHED_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] defer_cnt_q;
  logic [15:0] squash_cnt_q;
  logic        stall_ev;
  logic        squash_ev;

  assign stall_ev  = core_wb_valid && !core_wb_ready;
  assign squash_ev = mem_rsp_valid && squash_q[mem_rsp_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      defer_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (push && (defer_cnt_q != '1)) begin
        defer_cnt_q <= defer_cnt_q + 32'd1;
      end
      if (squash_ev && (squash_cnt_q != '1)) begin
        squash_cnt_q <= squash_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign defer_cnt  = defer_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: doc/wb_sched.md
Name: wb_sched

Overview:
- Sequences the single register-file write port in the RISC-V core.
- Shares the port between two requesters:
  - in-order core writebacks, using sources PC+4, ALU result or U-immediate;
  - variable-latency load returns from data memory.
- Memory returns always win the port. Core writes displaced by a return wait in a small in-order queue. A per-register scoreboard keeps write-after-write order correct across the two paths.

Parameters:
- DEPTH, 2, core-writeback queue entries; power of two, 2..8.
- XLEN, 32, datapath width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- core_wb_valid  input  1  core writeback request.
- core_wb_ready  output  1  request accepted this cycle; equals queue not full.
- core_wb_rd  input  5  destination register.
- core_wb_sel  input  2  source select: 00 pcplus4, 01 result, 10 immu; 11 illegal on this path.
- pcplus4, result, immu  input  XLEN each  candidate write data.
- ld_issue_valid  input  1  load issued to memory.
- ld_issue_rd  input  5  load destination.
- mem_rsp_valid  input  1  load data returning; cannot be back-pressured.
- mem_rsp_rd  input  5  returning load destination.
- readmemdata  input  XLEN  returning load data.
- rf_we  output  1  register-file write enable, registered.
- rf_waddr  output  5  write address, registered.
- rf_wdata  output  XLEN  write data, registered.
- wb_src  output  2  source of the current write, same encoding as core_wb_sel; 11 means load.
- ld_pending  output  32  scoreboard; bit n set means a load to xn is outstanding.

Behaviour:
- Reset (synchronous, active-high):
  - rf_we=0, rf_waddr=0, rf_wdata=0, wb_src=00, ld_pending=0.
  - Queue emptied; all squash bits cleared.
  - Reset mid-operation discards queued writes and outstanding-load tracking.
  - Responses arriving in the cycle rst is high are ignored.
- Core accept: core_wb_valid && core_wb_ready.
  - Data is selected at accept time and stored as {rd, sel, data}.
  - core_wb_sel=11 is treated as a no-op accept: no write, no queue entry.
- Port arbitration, evaluated every cycle, output registered (1-cycle latency):
  1. mem_rsp_valid: write readmemdata to mem_rsp_rd, wb_src=11, unless squashed or rd=0.
  2. else queue non-empty: pop head and write it.
  3. else accepted core request: bypass the queue and write directly.
  4. else rf_we=0.
- An accepted core request that does not win the port is pushed to the queue tail. Order among core writes is always preserved.
- Push and pop in the same cycle are allowed. The count stays the same when both occur.
- Full: count==DEPTH, so core_wb_ready=0 and the core must hold its request stable.
  - Ready is combinational from the count only.
- Scoreboard:
  - ld_issue_valid with rd≠0 sets pending[rd] and clears squash[rd].
  - mem_rsp_valid clears pending[rd] and squash[rd].
  - Issue and response to the same rd in the same cycle: the issue wins, so the bit stays set.
- WAW handling:
  - A core write accepted to rd with pending[rd]=1 sets squash[rd].
  - The later load response for that rd is consumed but suppressed (rf_we=0). The core value stands.
- x0: any write to rd=0 drives rf_we=0. ld_issue to x0 does not set pending.
- A response with pending[rd]=0 is still written (no error here).
- Queue pointers are log2(DEPTH) bits wide and wrap naturally.

Optional Feature:
- WB_SCHED_PERF_EN defined:
  - adds output stall_cnt (32 bits): cycles with core_wb_valid && !core_wb_ready;
  - adds output defer_cnt (32 bits): accepted core writes that were queued rather than bypassed;
  - adds output squash_cnt (16 bits): suppressed load responses;
  - all counters saturate and are cleared by rst.
- Not defined: these ports and counters are absent. Functional behaviour is identical.

Test Plan:
- Bypass path:
  - stimulus: rst then idle, then core_wb_valid, rd=5, sel=01, result=16;
  - required: next cycle rf_we=1, rf_waddr=5, rf_wdata=16, wb_src=01.
- Source selects: sel 00 with pcplus4=4, then 10 with immu=32, rd=3 each -> rf_wdata 4, then 32, with matching wb_src.
- Collision:
  - stimulus: mem_rsp_valid rd=7 data=48 in the same cycle as core rd=8 sel=10 immu=32;
  - required: cycle+1 writes x7=48 (wb_src=11); cycle+2 writes x8=32; defer_cnt=1 when enabled.
- Full:
  - stimulus: DEPTH=2, mem_rsp_valid held 3 cycles while the core issues writes continuously;
  - required: core_wb_ready drops after 2 accepts; queue drains in order once responses stop.
- WAW:
  - stimulus: ld_issue rd=9; core write rd=9 result=16; then mem_rsp rd=9 data=48;
  - required: x9 written 16 only; response write suppressed; ld_pending[9] clears.
- Reset and x0:
  - reset asserted with 2 entries queued -> no further rf_we, ld_pending=0;
  - core write with rd=0 -> rf_we stays 0.
